// File: rtl/param_clamp_bank.sv
// Parameter qualification bank: snapshots a flat parameter vector, clamps and de-biases
// one channel per cycle, then commits every channel at once (optionally on frame_sync).
module param_clamp_bank #(
    parameter int unsigned                  NUM_CH         = 8,
    parameter int unsigned                  DATA_W         = 32,
    parameter logic [NUM_CH*DATA_W-1:0]     MIN_VEC        = '0,
    parameter logic [NUM_CH*DATA_W-1:0]     MAX_VEC        = '1,
    parameter logic [NUM_CH*DATA_W-1:0]     OFS_VEC        = '0,
    parameter logic [NUM_CH-1:0]            CLAMP_EN       = '1,
    parameter bit                           COMMIT_ON_SYNC = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH*DATA_W-1:0] i_param_in,
    input  logic                     i_load_param,
    input  logic                     i_frame_sync,
    output logic [NUM_CH*DATA_W-1:0] o_param_out,
    output logic [NUM_CH-1:0]        o_ovf_flags,
    output logic [NUM_CH-1:0]        o_udf_flags,
    output logic                     o_busy,
    output logic                     o_pending,
    output logic                     o_updated
);

    localparam int unsigned      IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StWaitSync,
        StCommit
    } state_e;

    state_e                     r_state;
    state_e                     w_state_nxt;
    logic                       r_load_d;
    logic                       r_req;
    logic [IDX_W-1:0]           r_idx;
    logic [NUM_CH*DATA_W-1:0]   r_in_buf;
    logic [NUM_CH*DATA_W-1:0]   r_stage;
    logic [NUM_CH-1:0]          r_sovf;
    logic [NUM_CH-1:0]          r_sudf;
    logic [NUM_CH*DATA_W-1:0]   r_param_out;
    logic [NUM_CH-1:0]          r_ovf_flags;
    logic [NUM_CH-1:0]          r_udf_flags;
    logic                       r_updated;

    logic                       w_rise;
    logic                       w_capture;
    logic                       w_latch_set;
    logic                       w_scan_wr;
    logic                       w_commit;
    logic [DATA_W-1:0]          w_x;
    logic [DATA_W-1:0]          w_min;
    logic [DATA_W-1:0]          w_max;
    logic [DATA_W-1:0]          w_ofs;
    logic [DATA_W-1:0]          w_y;
    logic [DATA_W-1:0]          w_res;
    logic                       w_ovf;
    logic                       w_udf;

    assign w_rise = i_load_param & ~r_load_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_latch_set = 1'b0;
        w_scan_wr   = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_rise || r_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StScan;
                end
            end
            StScan: begin
                w_scan_wr   = 1'b1;
                w_latch_set = w_rise;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = COMMIT_ON_SYNC ? StWaitSync : StCommit;
                end
            end
            StWaitSync: begin
                // A new request beats a coincident frame_sync: rescan rather than commit stale data.
                if (w_rise) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StScan;
                end else if (i_frame_sync) begin
                    w_state_nxt = StCommit;
                end
            end
            StCommit: begin
                w_commit    = 1'b1;
                w_latch_set = w_rise;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
        o_busy    = (r_state != StIdle);
        o_pending = (r_state == StWaitSync);
    end

    // Per-channel qualification of the channel currently selected by the scan index.
    always_comb begin
        w_x   = r_in_buf[r_idx*DATA_W +: DATA_W];
        w_min = MIN_VEC[r_idx*DATA_W +: DATA_W];
        w_max = MAX_VEC[r_idx*DATA_W +: DATA_W];
        w_ofs = OFS_VEC[r_idx*DATA_W +: DATA_W];
        w_ovf = 1'b0;
        w_udf = 1'b0;
        w_y   = w_x;
        if (CLAMP_EN[r_idx] && (w_x > w_max)) begin
            w_y   = w_max;
            w_ovf = 1'b1;
        end else if (CLAMP_EN[r_idx] && (w_x < w_min)) begin
            w_y   = w_min;
            w_udf = 1'b1;
        end
        w_res = (w_y >= w_ofs) ? (w_y - w_ofs) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_load_d    <= 1'b0;
            r_req       <= 1'b0;
            r_idx       <= '0;
            r_in_buf    <= '0;
            r_stage     <= '0;
            r_sovf      <= '0;
            r_sudf      <= '0;
            r_param_out <= '0;
            r_ovf_flags <= '0;
            r_udf_flags <= '0;
            r_updated   <= 1'b0;
        end else begin
            r_load_d  <= i_load_param;
            r_updated <= 1'b0;

            if (w_capture) begin
                r_in_buf <= i_param_in;
                r_idx    <= '0;
            end else if (w_scan_wr && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_scan_wr) begin
                r_stage[r_idx*DATA_W +: DATA_W] <= w_res;
                r_sovf[r_idx]                   <= w_ovf;
                r_sudf[r_idx]                   <= w_udf;
            end

            // One-deep request latch; a fresh capture satisfies any pending request.
            if (w_capture) begin
                r_req <= 1'b0;
            end else if (w_latch_set) begin
                r_req <= 1'b1;
            end

            if (w_commit) begin
                r_param_out <= r_stage;
                r_ovf_flags <= r_sovf;
                r_udf_flags <= r_sudf;
                r_updated   <= 1'b1;
            end
        end
    end

    assign o_param_out = r_param_out;
    assign o_ovf_flags = r_ovf_flags;
    assign o_udf_flags = r_udf_flags;
    assign o_updated   = r_updated;

endmodule

// File: tb/tb_param_clamp_bank.sv
// Directed bench for param_clamp_bank: immediate-commit and frame-sync instances,
// with expected results queued at stimulus time and compared on each update pulse.
module tb_param_clamp_bank;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 16;
    localparam logic [63:0] MIN_VEC  = {16'd0, 16'd0, 16'd10, 16'd0};
    localparam logic [63:0] MAX_VEC  = {16'd500, 16'd65535, 16'd1000, 16'd9999};
    localparam logic [63:0] OFS_VEC  = {16'd0, 16'd0, 16'd10, 16'd0};
    localparam logic [3:0]  CLAMP_EN = 4'b1011;

    typedef struct packed {
        logic [63:0] out;
        logic [3:0]  ovf;
        logic [3:0]  udf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a_in, b_in;
    logic        a_load, b_load, a_fs, b_fs;
    logic [63:0] a_out, b_out;
    logic [3:0]  a_ovf, a_udf, b_ovf, b_udf;
    logic        a_busy, a_pend, a_upd, b_busy, b_pend, b_upd;

    int   n_checks = 0;
    int   n_err    = 0;
    res_t q_a[$];
    res_t q_b[$];

    always #5 clk = ~clk;

    param_clamp_bank #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MIN_VEC(MIN_VEC), .MAX_VEC(MAX_VEC),
        .OFS_VEC(OFS_VEC), .CLAMP_EN(CLAMP_EN), .COMMIT_ON_SYNC(1'b0)
    ) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_param_in(a_in), .i_load_param(a_load),
        .i_frame_sync(a_fs), .o_param_out(a_out), .o_ovf_flags(a_ovf),
        .o_udf_flags(a_udf), .o_busy(a_busy), .o_pending(a_pend), .o_updated(a_upd)
    );

    param_clamp_bank #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MIN_VEC(MIN_VEC), .MAX_VEC(MAX_VEC),
        .OFS_VEC(OFS_VEC), .CLAMP_EN(CLAMP_EN), .COMMIT_ON_SYNC(1'b1)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_param_in(b_in), .i_load_param(b_load),
        .i_frame_sync(b_fs), .o_param_out(b_out), .o_ovf_flags(b_ovf),
        .o_udf_flags(b_udf), .o_busy(b_busy), .o_pending(b_pend), .o_updated(b_upd)
    );

    function automatic logic [63:0] vec(input int c0, input int c1, input int c2, input int c3);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    function automatic res_t model(input logic [63:0] v);
        res_t        r;
        logic [15:0] x, y, mn, mx, of;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            x  = v[i*16 +: 16];
            mn = MIN_VEC[i*16 +: 16];
            mx = MAX_VEC[i*16 +: 16];
            of = OFS_VEC[i*16 +: 16];
            y  = x;
            if (CLAMP_EN[i] && x > mx) begin
                y = mx;
                r.ovf[i] = 1'b1;
            end else if (CLAMP_EN[i] && x < mn) begin
                y = mn;
                r.udf[i] = 1'b1;
            end
            r.out[i*16 +: 16] = (y >= of) ? y - of : 16'd0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_a(input string tag);
        res_t e;
        if (q_a.size() == 0) begin
            chk({tag, "_qempty"}, 64'd1, {63'd0, a_upd});
            return;
        end
        e = q_a.pop_front();
        chk({tag, "_out"}, a_out, e.out);
        chk({tag, "_ovf"}, {60'd0, a_ovf}, {60'd0, e.ovf});
        chk({tag, "_udf"}, {60'd0, a_udf}, {60'd0, e.udf});
    endtask

    task automatic pop_b(input string tag);
        res_t e;
        if (q_b.size() == 0) begin
            chk({tag, "_qempty"}, 64'd1, {63'd0, b_upd});
            return;
        end
        e = q_b.pop_front();
        chk({tag, "_out"}, b_out, e.out);
        chk({tag, "_ovf"}, {60'd0, b_ovf}, {60'd0, e.ovf});
        chk({tag, "_udf"}, {60'd0, b_udf}, {60'd0, e.udf});
    endtask

    // Waits for DUT A's update pulse, checking latency and that param_out held meanwhile.
    task automatic wait_upd_a(input int exp_lat, input string tag);
        int          lat;
        bit          seen;
        bit          stable;
        logic [63:0] old;
        old    = a_out;
        stable = 1'b1;
        seen   = 1'b0;
        lat    = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (a_upd) seen = 1'b1;
            else if (a_out !== old) stable = 1'b0;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_hold"}, {63'd0, stable}, 64'd1);
        pop_a(tag);
    endtask

    initial begin
        int npulse;
        rst = 1'b1;
        a_in = '0; b_in = '0; a_load = 0; b_load = 0; a_fs = 0; b_fs = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out", a_out, 64'd0);
        chk("rst_flags", {56'd0, a_ovf, a_udf}, 64'd0);
        chk("rst_ctl", {61'd0, a_busy, a_pend, a_upd}, 64'd0);

        // Basic clamp
        a_in = vec(12000, 5, 7, 800);
        q_a.push_back(model(a_in));
        a_load = 1'b1;
        @(negedge clk);
        a_load = 1'b0;
        chk("basic_busy", {63'd0, a_busy}, 64'd1);
        wait_upd_a(5, "basic");
        chk("basic_const", a_out, vec(9999, 0, 7, 500));
        chk("basic_ovf_const", {60'd0, a_ovf}, 64'b1001);
        @(negedge clk);
        chk("basic_pulse", {63'd0, a_upd}, 64'd0);

        // In range
        a_in = vec(100, 50, 65535, 0);
        q_a.push_back(model(a_in));
        a_load = 1'b1;
        wait_upd_a(6, "inrange");
        a_load = 1'b0;
        chk("inrange_const", a_out, vec(100, 40, 65535, 0));
        @(negedge clk);

        // Level held high for 20 cycles gives exactly one commit
        a_in = vec(20000, 2000, 9, 600);
        q_a.push_back(model(a_in));
        a_load = 1'b1;
        npulse = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (k == 19) a_load = 1'b0;
            if (a_upd) begin
                npulse++;
                pop_a("hold");
            end
        end
        chk("hold_pulses", 64'(npulse), 64'd1);

        // Second rise during SCAN; param_in change after E0 must not leak into first load
        a_in = vec(1, 2, 3, 4);
        q_a.push_back(model(a_in));
        q_a.push_back(model(vec(300, 300, 300, 300)));
        a_load = 1'b1;
        @(negedge clk);
        a_load = 1'b0;
        a_in   = vec(300, 300, 300, 300);
        @(negedge clk);
        a_load = 1'b1;
        wait_upd_a(4, "dbl1");
        a_load = 1'b0;
        wait_upd_a(6, "dbl2");

        // Reset mid-scan
        a_in = vec(11, 22, 33, 44);
        a_load = 1'b1;
        @(negedge clk);
        a_load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_out", a_out, 64'd0);
        chk("mrst_flags", {56'd0, a_ovf, a_udf}, 64'd0);
        chk("mrst_ctl", {61'd0, a_busy, a_pend, a_upd}, 64'd0);
        repeat (8) @(negedge clk);
        chk("mrst_idle_out", a_out, 64'd0);
        q_a.push_back(model(a_in));
        a_load = 1'b1;
        wait_upd_a(6, "postrst");
        a_load = 1'b0;

        // Frame-sync commit on instance B
        b_in = vec(12000, 5, 7, 800);
        q_b.push_back(model(b_in));
        b_load = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k == 0) b_load = 1'b0;
            if (k == 3) chk("fs_pend_early", {63'd0, b_pend}, 64'd0);
            if (k == 4) chk("fs_pend_on", {63'd0, b_pend}, 64'd1);
            if (k == 11) begin
                chk("fs_pend_hold", {63'd0, b_pend}, 64'd1);
                chk("fs_out_hold", b_out, 64'd0);
                b_fs = 1'b1;
            end
            if (k == 12) begin
                b_fs = 1'b0;
                chk("fs_no_upd_yet", {63'd0, b_upd}, 64'd0);
                chk("fs_out_old", b_out, 64'd0);
            end
            if (k == 13) begin
                chk("fs_upd", {63'd0, b_upd}, 64'd1);
                chk("fs_pend_off", {63'd0, b_pend}, 64'd0);
                pop_b("fs");
            end
        end

        // Restart in WAIT_SYNC: rise coincident with frame_sync wins
        b_in = vec(1, 2, 3, 4);
        b_load = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k == 0) b_load = 1'b0;
            if (k == 6) begin
                chk("rs_pend", {63'd0, b_pend}, 64'd1);
                b_in = vec(20000, 2000, 9, 600);
                q_b.push_back(model(b_in));
                b_load = 1'b1;
                b_fs = 1'b1;
            end
            if (k == 7) begin
                b_load = 1'b0;
                b_fs = 1'b0;
                chk("rs_rescan", {62'd0, b_busy, b_pend}, 64'b10);
                chk("rs_no_upd", {63'd0, b_upd}, 64'd0);
            end
            if (k == 10) chk("rs_out_old", b_out, model(vec(12000, 5, 7, 800)).out);
            if (k == 14) b_fs = 1'b1;
            if (k == 15) begin
                b_fs = 1'b0;
                chk("rs_no_upd2", {63'd0, b_upd}, 64'd0);
            end
            if (k == 16) begin
                chk("rs_upd", {63'd0, b_upd}, 64'd1);
                pop_b("rs");
            end
        end

        chk("qa_empty", 64'(q_a.size()), 64'd0);
        chk("qb_empty", 64'(q_b.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
